// File: rtl/coax_rx_ctrl_if.sv
// Signal bundle between coax_rx_ctrl, the coax receiver and the host.
// slave is the controller's view; master is the receiver/host side.
interface coax_rx_ctrl_if #(
   parameter int DEPTH = 16
);
   localparam int CW = $clog2(DEPTH) + 1;

   // Host read handshake: rd_data is the head word whenever empty=0; a word
   // is consumed on a clock where rd_en=1 and empty=0 (rd_en with empty=1 is a no-op).
   logic          enable;
   logic          rx_active;
   logic          rx_error;
   logic          rx_strobe;
   logic [9:0]    rx_data;
   logic          rx_reset;
   logic          rd_en;
   logic [9:0]    rd_data;
   logic          empty;
   logic [CW-1:0] count;
   logic          frame_done;
   logic          error;
   logic [3:0]    error_code;
   logic          error_ack;
   logic [2:0]    state_dbg;

   modport master (
      output enable, rx_active, rx_error, rx_strobe, rx_data, rd_en, error_ack,
      input  rx_reset, rd_data, empty, count, frame_done, error, error_code, state_dbg
   );

   modport slave (
      input  enable, rx_active, rx_error, rx_strobe, rx_data, rd_en, error_ack,
      output rx_reset, rd_data, empty, count, frame_done, error, error_code, state_dbg
   );
endinterface

// File: rtl/coax_rx_ctrl.sv
// Frame-level coax receive controller: receiver reset/enable sequencing, FWFT word FIFO,
// sticky error handling. Define COAX_RX_CTRL_TIMEOUT_EN to build the receive timeout counter.
module coax_rx_ctrl #(
   parameter int DEPTH           = 16,
   parameter int TIMEOUT_CLOCKS  = 256,
   parameter int RX_RESET_CLOCKS = 4
) (
   input  logic          clk,
   input  logic          reset_n,
   coax_rx_ctrl_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int RW = $clog2(RX_RESET_CLOCKS) + 1;

   typedef enum logic [2:0] {
      S_DISABLED = 3'd0,
      S_RECOVER  = 3'd1,
      S_IDLE     = 3'd2,
      S_RECEIVE  = 3'd3,
      S_DONE     = 3'd4,
      S_ERROR    = 3'd5
   } state_t;

   state_t        state, state_nx;
   logic [9:0]    mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] count, count_nx;
   logic [RW-1:0] rcv_cnt;
   logic          active_q, rx_reset_q, frame_done_q, error_q;
   logic [3:0]    code_q, code_nx;
   logic          rise, fall, full, push, pop, flush;
   logic          timeout;

`ifdef COAX_RX_CTRL_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CLOCKS) + 1;
   logic [TW-1:0] to_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) to_cnt <= '0;
      else if (state != S_RECEIVE || bus.rx_strobe) to_cnt <= '0;
      else if (to_cnt != TW'(TIMEOUT_CLOCKS)) to_cnt <= to_cnt + 1'b1;
   end

   assign timeout = (state == S_RECEIVE) && (to_cnt == TW'(TIMEOUT_CLOCKS));
`else
   // No counter in this build; the expression is constant false for any legal TIMEOUT_CLOCKS.
   assign timeout = (TIMEOUT_CLOCKS < 0);
`endif

   always_comb begin
      rise     = bus.rx_active & ~active_q;
      fall     = ~bus.rx_active & active_q;
      full     = (count == CW'(DEPTH));
      pop      = bus.rd_en && (count != '0) && (state != S_ERROR);
      push     = 1'b0;
      flush    = 1'b0;
      state_nx = state;
      code_nx  = code_q;
      case (state)
         S_DISABLED: if (bus.enable) state_nx = S_RECOVER;
         S_RECOVER:  if (rcv_cnt == RW'(RX_RESET_CLOCKS - 1)) state_nx = S_IDLE;
         S_IDLE:     if (rise) state_nx = S_RECEIVE;
         S_RECEIVE: begin
            if (bus.rx_error) begin
               state_nx = S_ERROR;
               code_nx  = 4'd1;
            end else if (timeout) begin
               state_nx = S_ERROR;
               code_nx  = 4'd3;
            end else if (bus.rx_strobe && full && !pop) begin
               state_nx = S_ERROR;
               code_nx  = 4'd2;
            end else begin
               push = bus.rx_strobe;
               // A word strobed together with the falling edge still belongs to the frame.
               if (fall)
                  state_nx = ((count + CW'(push) - CW'(pop)) != '0) ? S_DONE : S_IDLE;
            end
         end
         S_DONE: begin
            if (rise) begin
               state_nx = S_ERROR;
               code_nx  = 4'd2;
            end else if (pop && count == CW'(1)) begin
               state_nx = S_IDLE;
            end
         end
         S_ERROR: begin
            if (bus.error_ack) begin
               state_nx = S_RECOVER;
               code_nx  = 4'd0;
            end
         end
         default: state_nx = S_DISABLED;
      endcase
      if (!bus.enable) begin
         state_nx = S_DISABLED;
         code_nx  = 4'd0;
      end
      if (state == S_DISABLED ||
          (state_nx != state &&
           (state_nx == S_RECOVER || state_nx == S_ERROR || state_nx == S_DISABLED)))
         flush = 1'b1;
      if (flush) begin
         push = 1'b0;
         pop  = 1'b0;
      end
      count_nx = flush ? '0 : count + CW'(push) - CW'(pop);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= S_DISABLED;
         rcv_cnt      <= '0;
         active_q     <= 1'b0;
         rx_reset_q   <= 1'b1;
         frame_done_q <= 1'b0;
         error_q      <= 1'b0;
         code_q       <= 4'd0;
         count        <= '0;
         rd_ptr       <= '0;
         wr_ptr       <= '0;
      end else begin
         state        <= state_nx;
         rcv_cnt      <= (state == S_RECOVER) ? rcv_cnt + 1'b1 : '0;
         active_q     <= bus.rx_active;
         rx_reset_q   <= (state_nx == S_DISABLED) || (state_nx == S_RECOVER);
         frame_done_q <= (state_nx == S_DONE);
         error_q      <= (state_nx == S_ERROR);
         code_q       <= code_nx;
         count        <= count_nx;
         if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= bus.rx_data;
   end

   assign bus.rx_reset   = rx_reset_q;
   assign bus.rd_data    = (count == '0) ? 10'd0 : mem[rd_ptr];
   assign bus.empty      = (count == '0);
   assign bus.count      = count;
   assign bus.frame_done = frame_done_q;
   assign bus.error      = error_q;
   assign bus.error_code = code_q;
   assign bus.state_dbg  = state;
endmodule

// File: tb/tb_coax_rx_ctrl.sv
// Directed + randomized bench for coax_rx_ctrl; the buffered words are modelled as a queue.
module tb_coax_rx_ctrl;
   localparam int DEPTH           = 16;
   localparam int TIMEOUT_CLOCKS  = 256;
   localparam int RX_RESET_CLOCKS = 4;
   localparam int W               = 10;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   int   checks  = 0;
   int   errors  = 0;
   logic [W-1:0] exp_q[$];

   coax_rx_ctrl_if #(.DEPTH(DEPTH)) bus ();

   coax_rx_ctrl #(
      .DEPTH(DEPTH),
      .TIMEOUT_CLOCKS(TIMEOUT_CLOCKS),
      .RX_RESET_CLOCKS(RX_RESET_CLOCKS)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "bench did not finish");
   end

   // driver / checker tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_rx_reset"},   32'(bus.rx_reset),   1);
      check({tag, "_empty"},      32'(bus.empty),      1);
      check({tag, "_count"},      32'(bus.count),      0);
      check({tag, "_rd_data"},    32'(bus.rd_data),    0);
      check({tag, "_frame_done"}, 32'(bus.frame_done), 0);
      check({tag, "_error"},      32'(bus.error),      0);
      check({tag, "_error_code"}, 32'(bus.error_code), 0);
   endtask

   // Counts consecutive clocks with rx_reset high, starting with the current sample.
   task automatic count_reset_high(input string tag);
      int n = 0;
      while (bus.rx_reset && n < 20) begin
         n++;
         step();
      end
      check({tag, "_rx_reset_len"}, 32'(n), 32'(RX_RESET_CLOCKS));
   endtask

   task automatic strobe_word(input logic [W-1:0] d);
      bus.rx_strobe = 1'b1;
      bus.rx_data   = d;
      step();
      bus.rx_strobe = 1'b0;
      exp_q.push_back(d);
   endtask

   task automatic drain(input string tag);
      while (exp_q.size() > 0) begin
         check({tag, "_rd_data"}, 32'(bus.rd_data), 32'(exp_q[0]));
         bus.rd_en = 1'b1;
         step();
         bus.rd_en = 1'b0;
         void'(exp_q.pop_front());
         check({tag, "_count"}, 32'(bus.count), 32'(exp_q.size()));
      end
      check({tag, "_empty"},      32'(bus.empty),      1);
      check({tag, "_frame_done"}, 32'(bus.frame_done), 0);
   endtask

   // stimulus
   initial begin
      int n;
      int sent;
      logic s, r, popped;
      logic [W-1:0] d;

      bus.enable    = 1'b0;
      bus.rx_active = 1'b0;
      bus.rx_error  = 1'b0;
      bus.rx_strobe = 1'b0;
      bus.rx_data   = '0;
      bus.rd_en     = 1'b0;
      bus.error_ack = 1'b0;

      repeat (3) step();
      check_reset_values("reset");
      reset_n = 1'b1;
      step();
      step();
      check("disabled_rx_reset", 32'(bus.rx_reset), 1);

      // 3-word frame
      bus.enable = 1'b1;
      step();
      count_reset_high("startup");
      check("idle_error", 32'(bus.error), 0);
      bus.rx_active = 1'b1;
      step();
      strobe_word(10'h3FF);
      check("first_word_rd_data", 32'(bus.rd_data), 32'h3FF);
      check("first_word_empty",   32'(bus.empty),   0);
      strobe_word(10'h001);
      strobe_word(10'h155);
      bus.rx_active = 1'b0;
      step();
      check("t1_frame_done", 32'(bus.frame_done), 1);
      check("t1_count",      32'(bus.count),      3);
      drain("t1");

      // random streaming frame: host reads while words arrive
      bus.rx_active = 1'b1;
      step();
      n    = $urandom_range(5, 12);
      sent = 0;
      for (int c = 0; c < 60 && sent < n; c++) begin
         s = 1'($urandom_range(0, 1));
         r = 1'($urandom_range(0, 1));
         d = W'($urandom_range(0, 1023));
         bus.rx_strobe = s;
         bus.rx_data   = d;
         bus.rd_en     = r;
         popped = r && (exp_q.size() > 0);
         if (popped) check("stream_rd_data", 32'(bus.rd_data), 32'(exp_q[0]));
         step();
         if (popped) void'(exp_q.pop_front());
         if (s) begin
            exp_q.push_back(d);
            sent++;
         end
         check("stream_count", 32'(bus.count), 32'(exp_q.size()));
      end
      bus.rx_strobe = 1'b0;
      bus.rd_en     = 1'b0;
      bus.rx_active = 1'b0;
      step();
      check("stream_frame_done", 32'(bus.frame_done), 32'(exp_q.size() > 0));
      drain("stream");

      // full FIFO with a simultaneous pop and push
      bus.rx_active = 1'b1;
      step();
      for (int i = 0; i < DEPTH; i++) strobe_word(W'($urandom_range(0, 1023)));
      check("full_count", 32'(bus.count), 32'(DEPTH));
      d = W'($urandom_range(0, 1023));
      bus.rx_strobe = 1'b1;
      bus.rx_data   = d;
      bus.rd_en     = 1'b1;
      check("full_pp_rd_data", 32'(bus.rd_data), 32'(exp_q[0]));
      step();
      bus.rx_strobe = 1'b0;
      bus.rd_en     = 1'b0;
      void'(exp_q.pop_front());
      exp_q.push_back(d);
      check("full_pp_count", 32'(bus.count), 32'(DEPTH));
      check("full_pp_error", 32'(bus.error), 0);
      bus.rx_active = 1'b0;
      step();
      check("full_frame_done", 32'(bus.frame_done), 1);
      drain("full");

      // overrun: DEPTH+1 strobes with no reads
      bus.rx_active = 1'b1;
      step();
      for (int i = 0; i < DEPTH; i++) strobe_word(W'($urandom_range(0, 1023)));
      bus.rx_strobe = 1'b1;
      bus.rx_data   = W'($urandom_range(0, 1023));
      step();
      bus.rx_strobe = 1'b0;
      exp_q.delete();
      check("ovr_error",      32'(bus.error),      1);
      check("ovr_error_code", 32'(bus.error_code), 2);
      check("ovr_empty",      32'(bus.empty),      1);
      check("ovr_frame_done", 32'(bus.frame_done), 0);
      bus.rx_active = 1'b0;
      bus.error_ack = 1'b1;
      step();
      bus.error_ack = 1'b0;
      check("ack_error",      32'(bus.error),      0);
      check("ack_error_code", 32'(bus.error_code), 0);
      count_reset_high("ack");

      // receiver error after two words, then disable
      bus.rx_active = 1'b1;
      step();
      strobe_word(W'($urandom_range(0, 1023)));
      strobe_word(W'($urandom_range(0, 1023)));
      bus.rx_error = 1'b1;
      step();
      bus.rx_error = 1'b0;
      exp_q.delete();
      check("rxerr_error",      32'(bus.error),      1);
      check("rxerr_error_code", 32'(bus.error_code), 1);
      check("rxerr_empty",      32'(bus.empty),      1);
      check("rxerr_count",      32'(bus.count),      0);
      bus.rx_active = 1'b0;
      bus.enable    = 1'b0;
      step();
      check("dis_error",      32'(bus.error),      0);
      check("dis_error_code", 32'(bus.error_code), 0);
      check("dis_rx_reset",   32'(bus.rx_reset),   1);
      bus.enable = 1'b1;
      step();
      count_reset_high("reenable");

      // rx_active held with no strobes
      bus.rx_active = 1'b1;
      step();
      n = 0;
      while (!bus.error && n < 400) begin
         step();
         n++;
      end
`ifdef COAX_RX_CTRL_TIMEOUT_EN
      // The counter reaches the limit after TIMEOUT_CLOCKS idle clocks; the next clock acts on it.
      check("timeout_clocks",     32'(n),              32'(TIMEOUT_CLOCKS + 1));
      check("timeout_error_code", 32'(bus.error_code), 3);
`else
      check("no_timeout_clocks", 32'(n),              400);
      check("no_timeout_code",   32'(bus.error_code), 0);
`endif
      bus.rx_active = 1'b0;
      bus.enable    = 1'b0;
      step();
      check("to_dis_error", 32'(bus.error), 0);
      bus.enable = 1'b1;
      step();
      count_reset_high("to_reenable");

      // new frame start while a finished frame is still unread
      bus.rx_active = 1'b1;
      step();
      strobe_word(W'($urandom_range(0, 1023)));
      strobe_word(W'($urandom_range(0, 1023)));
      bus.rx_active = 1'b0;
      step();
      check("done2_frame_done", 32'(bus.frame_done), 1);
      check("done2_count",      32'(bus.count),      2);
      bus.rx_active = 1'b1;
      step();
      exp_q.delete();
      check("done_rise_error",      32'(bus.error),      1);
      check("done_rise_error_code", 32'(bus.error_code), 2);
      check("done_rise_empty",      32'(bus.empty),      1);
      check("done_rise_frame_done", 32'(bus.frame_done), 0);
      bus.rx_active = 1'b0;
      bus.error_ack = 1'b1;
      step();
      bus.error_ack = 1'b0;
      count_reset_high("ack2");

      // asynchronous reset in the middle of a frame
      bus.rx_active = 1'b1;
      step();
      for (int i = 0; i < 3; i++) strobe_word(W'($urandom_range(0, 1023)));
      check("pre_reset_count", 32'(bus.count), 3);
      #2;
      reset_n = 1'b0;
      #1;
      check_reset_values("async_reset");
      exp_q.delete();
      bus.rx_active = 1'b0;
      step();
      reset_n = 1'b1;
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/coax_rx_ctrl.md
# coax_rx_ctrl

Frame-level controller for the coax receiver. Sits between `coax_rx` and the host-side logic. It sequences the receiver's reset and enable and buffers decoded 10-bit words in a DEPTH-word first-word-fall-through FIFO. It also detects receiver, overrun and timeout errors and holds them until the host acknowledges, then recovers the receiver.

## Interface

**Parameters**
- `DEPTH`, 16: FIFO depth in words; a power of 2, at least 2.
- `TIMEOUT_CLOCKS`, 256: maximum number of clocks in RECEIVE without a word strobe.
- `RX_RESET_CLOCKS`, 4: number of clocks `rx_reset` is held in RECOVER.

**Ports**
- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  reset; asynchronous assert, active-low.
- `enable`  in  1  host enables reception.
- `rx_active`  in  1  from receiver; high while a frame is being received.
- `rx_error`  in  1  from receiver; high while the receiver is in its error state.
- `rx_strobe`  in  1  from receiver; one-cycle pulse per decoded word.
- `rx_data`  in  10  from receiver; word, valid when `rx_strobe`=1.
- `rx_reset`  out  1  drives the receiver `reset`.
- `rd_en`  in  1  pop the head word; ignored when `empty`=1 or in ERROR.
- `rd_data`  out  10  head word; valid when `empty`=0.
- `empty`  out  1  FIFO empty.
- `count`  out  $clog2(DEPTH)+1  number of words held.
- `frame_done`  out  1  a complete frame is buffered (state DONE).
- `error`  out  1  state ERROR.
- `error_code`  out  4  0 none, 1 receiver error, 2 overrun, 3 timeout.
- `error_ack`  in  1  host clears the error.

## Operation

- Reset values:
  - state = DISABLED.
  - `rx_reset`=1, `empty`=1, `count`=0, `rd_data`=0.
  - `frame_done`=0, `error`=0, `error_code`=0.
- **DISABLED**: `rx_reset`=1 and the FIFO is flushed. When `enable`=1, go to RECOVER.
- **RECOVER**: `rx_reset`=1 for exactly RX_RESET_CLOCKS cycles, then go to IDLE. The FIFO is flushed on entry.
- **IDLE**: `rx_reset`=0. A rising edge of `rx_active` goes to RECEIVE.
- **RECEIVE**: each `rx_strobe` writes `rx_data` into the FIFO.
  - `rx_strobe` while the FIFO is full and `rd_en`=0: go to ERROR with code 2.
  - `rx_strobe` with full and `rd_en`=1 in the same cycle: the pop and the push both happen, with no error.
  - `rx_error`=1: go to ERROR with code 1. This has priority over the strobe.
  - Falling edge of `rx_active`: go to DONE if `count`>0, otherwise IDLE.
  - The host may read while in RECEIVE (streaming).
- **DONE**: `frame_done`=1.
  - The cycle the FIFO becomes empty (last pop), go to IDLE.
  - A rising edge of `rx_active` goes to ERROR with code 2 (frame overrun).
- **ERROR**: `error`=1 and `error_code` is held.
  - The FIFO is flushed on entry; `rd_en` is ignored.
  - `error_ack`=1 goes to RECOVER and clears `error_code` to 0.
- `enable`=0 in any state goes to DISABLED next cycle and clears `error`/`error_code`. This has priority over every other transition.
- Edges of `rx_active` are detected against its registered previous value.
- FIFO pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. `count` saturates at exactly DEPTH; it never exceeds DEPTH.
- Receiver-error priority within a cycle: `enable`=0 > `rx_error` > timeout > overrun > write/read.

## Timing

- All outputs are registered except `rd_data` and `empty`, which are decoded from the registered head/count.
- A word strobed at cycle N is on `rd_data` with `empty`=0 at cycle N+1 (FIFO previously empty).
- A pop at cycle N presents the next word at N+1.
- State transitions take one cycle. `rx_reset` rises in the cycle the state becomes RECOVER or DISABLED.
- In RECOVER, `rx_reset` is high for RX_RESET_CLOCKS cycles and low in the first IDLE cycle.
- `frame_done` rises one cycle after the `rx_active` falling edge is sampled.
- A `reset_n` assertion mid-frame immediately forces the reset values; the FIFO contents are discarded.

## Configuration

- `COAX_RX_CTRL_TIMEOUT_EN` defined:
  - A counter of $clog2(TIMEOUT_CLOCKS)+1 bits clears on RECEIVE entry and on each `rx_strobe`, and increments otherwise.
  - When it reaches TIMEOUT_CLOCKS in RECEIVE, go to ERROR with code 3.
- Undefined: no counter is built, code 3 is never produced, and RECEIVE exits only on `rx_active` fall, `rx_error`, overrun or `enable`=0.

## Test plan

- Reset, `enable`=1, run a 3-word frame (0x3FF, 0x001, 0x155) -> `rx_reset` high 4 cycles; DONE with `count`=3; reads return words in order; IDLE after the third pop.
- DEPTH=16: 17 strobes with no reads -> ERROR, `error_code`=2, `empty`=1. `error_ack` -> RECOVER for 4 cycles, then IDLE.
- Full FIFO with `rd_en` and `rx_strobe` in the same cycle -> `count` stays 16, no error, the new word lands at the tail.
- `rx_error` pulse mid-frame after 2 words -> ERROR, code 1, FIFO flushed. `enable`=0 -> DISABLED, code 0.
- Timeout (macro defined, TIMEOUT_CLOCKS=256): `rx_active` high with no strobe for 256 cycles -> ERROR, code 3. With the macro undefined -> stays in RECEIVE.
- `rx_active` rises while in DONE with 2 unread words -> ERROR, code 2. `reset_n` low mid-frame -> all outputs at their reset values immediately.
